// File: rtl/ov7670_dvp_source.sv
// rtl/ov7670_dvp_source.sv - OV7670-style DVP frame generator (pclk/vsync/href/data)
// Define OV7670_SRC_COLORBAR_EN for 8 vertical colour bars instead of the line/column counting pattern.
module ov7670_dvp_source #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int H_BLANK      = 144,
    parameter int V_SYNC_LINES = 3,
    parameter int V_BACK_LINES = 17,
    parameter int PCLK_DIV     = 2
) (
    input  logic       clk,
    input  logic       buttonReset,
    input  logic       enable,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] OV7670_Data,
    output logic       frameDone
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HCNT_W   = $clog2(LINE_LEN + 1);
    localparam int SYNC_MAX = (V_SYNC_LINES > V_BACK_LINES) ? V_SYNC_LINES : V_BACK_LINES;
    localparam int VCNT_W   = $clog2(SYNC_MAX + 1);
    localparam int COL_W    = (H_ACTIVE > 256) ? $clog2(H_ACTIVE) : 8;
    localparam int LINE_W   = (V_ACTIVE > 256) ? $clog2(V_ACTIVE) : 8;
    localparam int DIV_W    = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                pclk_q, pclk_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                byte_q, byte_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                frame_done_q, frame_done_d;
    logic                toggle;
    logic                fall_tick;
    logic [15:0]         pixel;

    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            pclk_q       <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            col_q        <= '0;
            byte_q       <= 1'b0;
            line_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            pclk_q       <= pclk_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            col_q        <= col_d;
            byte_q       <= byte_d;
            line_q       <= line_d;
            frame_done_q <= frame_done_d;
        end
    end

    // pclk runs regardless of enable; every state change is tied to its falling edge
    always_comb begin
        toggle    = (div_q == DIV_W'(PCLK_DIV - 1));
        div_d     = toggle ? '0 : div_q + 1'b1;
        pclk_d    = toggle ? ~pclk_q : pclk_q;
        fall_tick = toggle & pclk_q;
    end

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        col_d        = col_q;
        byte_d       = byte_q;
        line_d       = line_q;
        frame_done_d = 1'b0;
        if (fall_tick) begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = VSYNC;
                        hcnt_d  = '0;
                        vcnt_d  = '0;
                    end
                end
                VSYNC: begin
                    if (hcnt_q == HCNT_W'(LINE_LEN - 1)) begin
                        hcnt_d = '0;
                        if (vcnt_q == VCNT_W'(V_SYNC_LINES - 1)) begin
                            state_d = VBACK;
                            vcnt_d  = '0;
                        end else begin
                            vcnt_d = vcnt_q + 1'b1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                VBACK: begin
                    if (hcnt_q == HCNT_W'(LINE_LEN - 1)) begin
                        hcnt_d = '0;
                        if (vcnt_q == VCNT_W'(V_BACK_LINES - 1)) begin
                            state_d = ACTIVE;
                            vcnt_d  = '0;
                            col_d   = '0;
                            byte_d  = 1'b0;
                            line_d  = '0;
                        end else begin
                            vcnt_d = vcnt_q + 1'b1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    byte_d = ~byte_q;
                    if (byte_q) begin
                        if (col_q == COL_W'(H_ACTIVE - 1)) begin
                            col_d   = '0;
                            hcnt_d  = '0;
                            state_d = HBLANK;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                HBLANK: begin
                    if (hcnt_q == HCNT_W'(H_BLANK - 1)) begin
                        hcnt_d = '0;
                        if (line_q < LINE_W'(V_ACTIVE - 1)) begin
                            state_d = ACTIVE;
                            line_d  = line_q + 1'b1;
                        end else begin
                            // enable is only looked at here and in IDLE, so frames are never cut short
                            line_d       = '0;
                            vcnt_d       = '0;
                            frame_done_d = 1'b1;
                            state_d      = enable ? VSYNC : IDLE;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef OV7670_SRC_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] bar_idx;
`endif

    always_comb begin
`ifdef OV7670_SRC_COLORBAR_EN
        bar_idx = 3'(col_q / COL_W'(BAR_W));
        case (bar_idx)
            3'd0:    pixel = 16'hFFFF;
            3'd1:    pixel = 16'hFFE0;
            3'd2:    pixel = 16'h07FF;
            3'd3:    pixel = 16'h07E0;
            3'd4:    pixel = 16'hF81F;
            3'd5:    pixel = 16'hF800;
            3'd6:    pixel = 16'h001F;
            default: pixel = 16'h0000;
        endcase
`else
        pixel = {line_q[7:0], col_q[7:0]};
`endif
        pclk        = pclk_q;
        vsync       = (state_q == VSYNC);
        href        = (state_q == ACTIVE);
        OV7670_Data = (state_q == ACTIVE) ? (byte_q ? pixel[7:0] : pixel[15:8]) : 8'h00;
        frameDone   = frame_done_q;
    end

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// tb/tb_ov7670_dvp_source.sv - directed self-checking bench for ov7670_dvp_source
module tb_ov7670_dvp_source;

    logic       clk = 1'b0;
    logic       buttonReset;
    logic       enable;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] OV7670_Data;
    logic       frameDone;

    always #5 clk = ~clk;

    ov7670_dvp_source #(
        .H_ACTIVE(16), .V_ACTIVE(4), .H_BLANK(4),
        .V_SYNC_LINES(1), .V_BACK_LINES(1), .PCLK_DIV(2)
    ) dut (
        .clk(clk), .buttonReset(buttonReset), .enable(enable),
        .pclk(pclk), .vsync(vsync), .href(href),
        .OV7670_Data(OV7670_Data), .frameDone(frameDone)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stab_viol = 0;
    int zero_viol = 0;
    int fd_count = 0;
    int fd_long = 0;
    int fd_last = 0;
    int fd_prev = 0;
    int href_rises = 0;
    int pclk_rises = 0;
    logic prev_pclk = 1'b0;
    logic prev_vs = 1'b0;
    logic prev_href = 1'b0;
    logic prev_fd = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] cap[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (prev_pclk && pclk && (vsync !== prev_vs || href !== prev_href || OV7670_Data !== prev_data))
            stab_viol++;
        if (!href && OV7670_Data !== 8'h00) zero_viol++;
        if (frameDone && !prev_fd) begin
            fd_count++;
            fd_prev = fd_last;
            fd_last = cyc;
        end
        if (frameDone && prev_fd) fd_long++;
        if (href && !prev_href) href_rises++;
        if (pclk && !prev_pclk) begin
            pclk_rises++;
            if (href) cap.push_back(OV7670_Data);
        end
        prev_pclk = pclk;
        prev_vs   = vsync;
        prev_href = href;
        prev_fd   = frameDone;
        prev_data = OV7670_Data;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return vsync;
            1:       return href;
            default: return vsync | href;
        endcase
    endfunction

    task automatic run_len(input int sel, input logic level, input int limit, output int n);
        n = 0;
        while (sig(sel) === level && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_for(input int sel, input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while (sig(sel) !== level && n < limit) begin
            n++;
            tick();
        end
        check(tag, sig(sel), level);
    endtask

    function automatic logic [7:0] exp_byte(input int line, input int k);
        logic [15:0] pix;
        int col;
`ifdef OV7670_SRC_COLORBAR_EN
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        col = k / 2;
        pix = bars[col / 2];
`else
        col = k / 2;
        pix = {8'(line), 8'(col)};
`endif
        return (k % 2 == 0) ? pix[15:8] : pix[7:0];
    endfunction

    initial begin
        int n, hi, r0, idle_bad, bad_other, fd0, hr0, busy;
        buttonReset = 1'b1;
        enable      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pclk", pclk, 1'b0);
        check("rst_vsync", vsync, 1'b0);
        check("rst_href", href, 1'b0);
        check("rst_data", OV7670_Data, 8'h00);
        check("rst_framedone", frameDone, 1'b0);

        buttonReset = 1'b0;
        hi = 0;
        idle_bad = 0;
        r0 = pclk_rises;
        repeat (200) begin
            tick();
            if (pclk) hi++;
            if (vsync || href || frameDone || OV7670_Data !== 8'h00) idle_bad++;
        end
        check("idle_pclk_high_samples", hi, 100);
        check("idle_pclk_rises", pclk_rises - r0, 50);
        check("idle_outputs_quiet", idle_bad, 0);

        enable = 1'b1;
        wait_for(0, 1'b1, 100, "frame1_vsync_start");
        cap.delete();
        check("frame1_href_in_vsync", href, 1'b0);
        run_len(0, 1'b1, 1000, n);
        check("vsync_len_clk", n, 144);
        run_len(1, 1'b0, 1000, n);
        check("vback_len_clk", n, 144);
        for (int l = 0; l < 4; l++) begin
            run_len(1, 1'b1, 1000, n);
            check($sformatf("line%0d_href_len_clk", l), n, 128);
            if (l < 3) begin
                run_len(1, 1'b0, 100, n);
                check($sformatf("line%0d_hblank_len_clk", l), n, 16);
            end
        end
        run_len(2, 1'b0, 100, n);
        check("last_hblank_len_clk", n, 16);
        check("framedone_at_frame_end", frameDone, 1'b1);
        check("frame2_vsync_back_to_back", vsync, 1'b1);

        check("captured_bytes", cap.size(), 128);
        if (cap.size() == 128) begin
            for (int k = 0; k < 32; k++)
                check($sformatf("line2_byte%0d", k), cap[64 + k], exp_byte(2, k));
            bad_other = 0;
            for (int l = 0; l < 4; l++)
                for (int k = 0; k < 32; k++)
                    if (l != 2 && cap[l * 32 + k] !== exp_byte(l, k)) bad_other++;
            check("other_lines_bytes", bad_other, 0);
        end

        fd0 = fd_count;
        hr0 = href_rises;
        run_len(0, 1'b1, 1000, n);
        run_len(1, 1'b0, 1000, n);
        run_len(1, 1'b1, 1000, n);
        run_len(1, 1'b0, 100, n);
        repeat (10) tick();
        enable = 1'b0;
        n = 0;
        while (fd_count == fd0 && n < 2000) begin
            n++;
            tick();
        end
        check("frame2_framedone_seen", fd_count, fd0 + 1);
        check("frame_period_clk", fd_last - fd_prev, 864);
        check("frame2_completes_4_lines", href_rises - hr0, 4);
        busy = 0;
        repeat (300) begin
            tick();
            if (vsync || href) busy++;
        end
        check("idle_after_enable_drop", busy, 0);
        check("no_extra_framedone", fd_count, fd0 + 1);

        enable = 1'b1;
        wait_for(0, 1'b1, 200, "frame3_vsync_start");
        wait_for(1, 1'b1, 2000, "frame3_line0");
        wait_for(1, 1'b0, 500, "frame3_line0_end");
        wait_for(1, 1'b1, 500, "frame3_line1");
        wait_for(1, 1'b0, 500, "frame3_line1_end");
        wait_for(1, 1'b1, 500, "frame3_line2");
        repeat (9) tick();
        #1 buttonReset = 1'b1;
        #1;
        check("midrst_pclk", pclk, 1'b0);
        check("midrst_vsync", vsync, 1'b0);
        check("midrst_href", href, 1'b0);
        check("midrst_data", OV7670_Data, 8'h00);
        check("midrst_framedone", frameDone, 1'b0);
        repeat (5) tick();
        buttonReset = 1'b0;
        wait_for(2, 1'b1, 200, "post_rst_first_sync");
        check("post_rst_vsync_first", vsync, 1'b1);
        check("post_rst_no_href", href, 1'b0);
        run_len(0, 1'b1, 1000, n);
        check("post_rst_vsync_len_clk", n, 144);
        run_len(1, 1'b0, 1000, n);
        check("post_rst_vback_len_clk", n, 144);

        check("stable_while_pclk_high", stab_viol, 0);
        check("data_zero_when_href_low", zero_viol, 0);
        check("framedone_single_clk", fd_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ov7670_dvp_source.md
OV7670_DVP_SOURCE -- requirements
Module: ov7670_dvp_source

Interface
REQ-001 Parameter H_ACTIVE, 320, pixels per active line; multiple of 8.
REQ-002 Parameter V_ACTIVE, 240, active lines per frame.
REQ-003 Parameter H_BLANK, 144, pclk periods with href low after each line.
REQ-004 Parameter V_SYNC_LINES, 3, line-times with vsync high.
REQ-005 Parameter V_BACK_LINES, 17, blank line-times between vsync fall and first active line.
REQ-006 Parameter PCLK_DIV, 2, clk cycles per pclk half-period; minimum 1.
REQ-007 clk  input  1  system clock; all logic clocked on rising edge.
REQ-008 buttonReset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  level; when high, frames are generated back to back.
REQ-010 pclk  output  1  camera pixel clock, registered.
REQ-011 vsync  output  1  frame sync, active high.
REQ-012 href  output  1  line valid, active high.
REQ-013 OV7670_Data  output  8  pixel byte bus.
REQ-014 frameDone  output  1  one-clk strobe at frame end.

Function
REQ-015 pclk SHALL toggle every PCLK_DIV clk cycles, free-running whenever reset is low, independent of enable.
REQ-016 vsync, href, OV7670_Data and state SHALL change only on the clk edge that drives pclk low ("fall tick"); they SHALL be stable while pclk is high.
REQ-017 Line-time SHALL be 2*H_ACTIVE + H_BLANK pclk periods for every line, including sync and back-porch lines.
REQ-018 FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK.
REQ-019 IDLE: all sync outputs low; enable high at a fall tick -> VSYNC.
REQ-020 VSYNC: vsync high for V_SYNC_LINES line-times -> VBACK.
REQ-021 VBACK: vsync and href low for V_BACK_LINES line-times -> ACTIVE.
REQ-022 ACTIVE: href high for exactly 2*H_ACTIVE pclk periods, one byte per period, RGB565 high byte first -> HBLANK.
REQ-023 HBLANK: href low H_BLANK periods; line counter < V_ACTIVE-1 -> ACTIVE (line counter +1); otherwise frame end.
REQ-024 Frame end: frameDone high for exactly one clk at the final fall tick; enable high -> VSYNC, else IDLE.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame; enable is sampled only in IDLE and at frame end.
REQ-026 OV7670_Data SHALL be 8'h00 whenever href is low.
REQ-027 Column counter range 0..H_ACTIVE-1, line counter range 0..V_ACTIVE-1; both wrap to 0, never exceed range.

Reset
REQ-028 buttonReset high SHALL immediately force pclk=0, vsync=0, href=0, OV7670_Data=8'h00, frameDone=0, state IDLE, all counters 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release the first frame SHALL begin with a full VSYNC period.

Configuration
REQ-030 Macro OV7670_SRC_COLORBAR_EN defined: pixel = 8 vertical bars of width H_ACTIVE/8, left to right 16'hFFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-031 Macro undefined: pixel = {line[7:0], column[7:0]} counting pattern; no colour-bar logic present.

Verification (H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, V_SYNC_LINES=1, V_BACK_LINES=1, PCLK_DIV=2)
REQ-032 Reset, enable=0 for 200 clk -> pclk period 4 clk; vsync=href=0, data=8'h00 throughout.
REQ-033 Enable=1 -> vsync high 36 pclks, low 36 pclks, then four href pulses of 32 pclks separated by 4 pclks; frameDone pulses once per 216 pclks.
REQ-034 Macro undefined, line 2 -> bytes 8'h02,8'h00,8'h02,8'h01,...,8'h02,8'h0F.
REQ-035 Macro defined, any line -> bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF,... ending 00,00; bar changes every 2 pixels.
REQ-036 Drop enable during line 1 -> frame completes all 4 lines, frameDone pulses, then IDLE with vsync low.
REQ-037 Assert buttonReset during ACTIVE line 2 -> outputs zero same cycle; after release first href preceded by full vsync pulse.
